// File: rtl/rtds_pkg.sv
// Shared encodings for the RTDS Aurora receive path: receive/trigger FSM states
// and the "any length" value for the expected-length configuration.
package rtds_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } rx_state_t;

    typedef enum logic {
        T_IDLE,
        T_WAIT
    } tx_state_t;

    localparam logic [15:0] LEN_ANY = '0;

endpackage

// File: rtl/rtds_frame_ram.sv
// Two-bank frame store: simple dual-port RAM, 2*MAX_WORDS words addressed as
// {bank, index}, synchronous read. Contents are never reset.
module rtds_frame_ram #(
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(MAX_WORDS):0]  wr_addr,
    input  logic [31:0]                 wr_data,
    input  logic [$clog2(MAX_WORDS):0]  rd_addr,
    output logic [31:0]                 rd_data
);

    logic [31:0] mem [2*MAX_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/rtds_rx_frame.sv
// RTDS Aurora RX frame receiver: double-buffered frame capture, length checking
// and delayed TX trigger. Define RTDS_RX_FRAME_TIMESTAMP_EN to add frame_ts.
module rtds_rx_frame
    import rtds_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 64,
    parameter int unsigned DELAY_W   = 16
) (
    input  logic                          user_clk,
    input  logic                          sys_reset,
    input  logic                          s_axis_tvalid,
    input  logic [31:0]                   s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic [15:0]                   cfg_expected_len,
    input  logic [DELAY_W-1:0]            cfg_tx_delay,
    input  logic [$clog2(MAX_WORDS)-1:0]  rd_addr,
    output logic [31:0]                   rd_data,
    output logic                          frame_done,
    output logic [15:0]                   frame_len,
    output logic [31:0]                   cnt_frames,
    output logic [15:0]                   cnt_dropped,
    output logic                          err_overflow,
    output logic                          err_len,
    output logic                          tx_trigger
`ifdef RTDS_RX_FRAME_TIMESTAMP_EN
    ,
    output logic [31:0]                   frame_ts
`endif
);

    localparam int unsigned AW   = $clog2(MAX_WORDS);
    localparam logic [AW:0] FULL = (AW+1)'(MAX_WORDS);

    rx_state_t   rx_state, rx_next;
    logic [AW:0] wr_cnt, cnt_next;
    logic        wr_bank;
    logic        we, tlast_beat, ovf, len_ok, accept, reject;
    logic [15:0] cur_len;

    // wr_cnt is held at 0 in IDLE, so word index and length share one path
    assign cur_len = 16'(wr_cnt) + 16'd1;
    assign len_ok  = (cfg_expected_len == LEN_ANY) || (cfg_expected_len == cur_len);
    assign accept  = tlast_beat && len_ok;
    assign reject  = tlast_beat && !len_ok;

    always_comb begin
        rx_next    = rx_state;
        cnt_next   = wr_cnt;
        we         = 1'b0;
        tlast_beat = 1'b0;
        ovf        = 1'b0;
        unique case (rx_state)
            IDLE, RECV: begin
                if (s_axis_tvalid) begin
                    if (wr_cnt == FULL) begin
                        ovf      = 1'b1;
                        cnt_next = '0;
                        rx_next  = s_axis_tlast ? IDLE : DROP;
                    end else begin
                        we = 1'b1;
                        if (s_axis_tlast) begin
                            tlast_beat = 1'b1;
                            cnt_next   = '0;
                            rx_next    = IDLE;
                        end else begin
                            cnt_next = wr_cnt + (AW+1)'(1);
                            rx_next  = RECV;
                        end
                    end
                end
            end
            DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    rx_next = IDLE;
                end
            end
            default: begin
                rx_next  = IDLE;
                cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge user_clk or posedge sys_reset) begin
        if (sys_reset) begin
            rx_state     <= IDLE;
            wr_cnt       <= '0;
            wr_bank      <= 1'b0;
            frame_done   <= 1'b0;
            frame_len    <= '0;
            cnt_frames   <= '0;
            cnt_dropped  <= '0;
            err_overflow <= 1'b0;
            err_len      <= 1'b0;
        end else begin
            rx_state   <= rx_next;
            wr_cnt     <= cnt_next;
            frame_done <= accept;
            if (accept) begin
                wr_bank    <= ~wr_bank;
                frame_len  <= cur_len;
                cnt_frames <= cnt_frames + 32'd1;
            end
            if (reject) begin
                err_len <= 1'b1;
            end
            if (ovf) begin
                err_overflow <= 1'b1;
            end
            if ((reject || ovf) && (cnt_dropped != '1)) begin
                cnt_dropped <= cnt_dropped + 16'd1;
            end
        end
    end

    // Published bank is always the one not being written
    rtds_frame_ram #(
        .MAX_WORDS(MAX_WORDS)
    ) u_ram (
        .clk    (user_clk),
        .we     (we),
        .wr_addr({wr_bank, wr_cnt[AW-1:0]}),
        .wr_data(s_axis_tdata),
        .rd_addr({~wr_bank, rd_addr}),
        .rd_data(rd_data)
    );

    tx_state_t          tx_state, tx_next;
    logic [DELAY_W-1:0] dly, dly_next;

    // Counter holds cycles remaining minus one, so zero delay triggers with frame_done
    always_comb begin
        tx_next    = tx_state;
        dly_next   = dly;
        tx_trigger = 1'b0;
        if (frame_done) begin
            if (cfg_tx_delay == '0) begin
                tx_trigger = 1'b1;
                tx_next    = T_IDLE;
            end else begin
                dly_next = cfg_tx_delay - DELAY_W'(1);
                tx_next  = T_WAIT;
            end
        end else if (tx_state == T_WAIT) begin
            if (dly == '0) begin
                tx_trigger = 1'b1;
                tx_next    = T_IDLE;
            end else begin
                dly_next = dly - DELAY_W'(1);
            end
        end
    end

    always_ff @(posedge user_clk or posedge sys_reset) begin
        if (sys_reset) begin
            tx_state <= T_IDLE;
            dly      <= '0;
        end else begin
            tx_state <= tx_next;
            dly      <= dly_next;
        end
    end

`ifdef RTDS_RX_FRAME_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge user_clk or posedge sys_reset) begin
        if (sys_reset) begin
            ts_cnt   <= '0;
            frame_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (accept) begin
                frame_ts <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rtds_rx_frame.sv
// Directed self-checking bench for rtds_rx_frame (MAX_WORDS=64, DELAY_W=16).
module tb_rtds_rx_frame;

    logic        user_clk = 1'b0;
    logic        sys_reset;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic [15:0] cfg_expected_len;
    logic [15:0] cfg_tx_delay;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        frame_done;
    logic [15:0] frame_len;
    logic [31:0] cnt_frames;
    logic [15:0] cnt_dropped;
    logic        err_overflow;
    logic        err_len;
    logic        tx_trigger;
`ifdef RTDS_RX_FRAME_TIMESTAMP_EN
    logic [31:0] frame_ts;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 user_clk = ~user_clk;

    rtds_rx_frame #(
        .MAX_WORDS(64),
        .DELAY_W  (16)
    ) dut (
        .user_clk        (user_clk),
        .sys_reset       (sys_reset),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tlast    (s_axis_tlast),
        .cfg_expected_len(cfg_expected_len),
        .cfg_tx_delay    (cfg_tx_delay),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .frame_done      (frame_done),
        .frame_len       (frame_len),
        .cnt_frames      (cnt_frames),
        .cnt_dropped     (cnt_dropped),
        .err_overflow    (err_overflow),
        .err_len         (err_len),
        .tx_trigger      (tx_trigger)
`ifdef RTDS_RX_FRAME_TIMESTAMP_EN
        ,
        .frame_ts        (frame_ts)
`endif
    );

    task automatic beat(input logic [31:0] d, input logic l);
        @(negedge user_clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
    endtask

    task automatic idle();
        @(negedge user_clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        sys_reset = 1'b1;
        #1;
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", frame_done); end
        checks++; if (frame_len !== 16'd0) begin failures++; $display("FAIL reset_len got=%0h exp=0", frame_len); end
        checks++; if (cnt_frames !== 32'd0) begin failures++; $display("FAIL reset_frames got=%0h exp=0", cnt_frames); end
        checks++; if (cnt_dropped !== 16'd0) begin failures++; $display("FAIL reset_dropped got=%0h exp=0", cnt_dropped); end
        checks++; if ({err_overflow, err_len} !== 2'b00) begin failures++; $display("FAIL reset_errs got=%0b exp=00", {err_overflow, err_len}); end
        checks++; if (tx_trigger !== 1'b0) begin failures++; $display("FAIL reset_trig got=%0h exp=0", tx_trigger); end
        repeat (3) @(negedge user_clk);
        sys_reset = 1'b0;
    endtask

    task automatic test_accept();
        logic [31:0] a [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
        cfg_expected_len = 16'd4;
        cfg_tx_delay     = 16'd3;
        beat(a[0], 1'b0);
        beat(a[1], 1'b0);
        // tlast without tvalid must be ignored
        @(negedge user_clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b1;
        beat(a[2], 1'b0);
        beat(a[3], 1'b1);
        idle();
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL accept_done got=%0h exp=1", frame_done); end
        checks++; if (frame_len !== 16'd4) begin failures++; $display("FAIL accept_len got=%0d exp=4", frame_len); end
        checks++; if (cnt_frames !== 32'd1) begin failures++; $display("FAIL accept_frames got=%0d exp=1", cnt_frames); end
        @(negedge user_clk);
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL accept_pulse got=%0h exp=0", frame_done); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 6'(i);
            @(negedge user_clk);
            checks++; if (rd_data !== a[i]) begin failures++; $display("FAIL accept_rd%0d got=%0h exp=%0h", i, rd_data, a[i]); end
        end
    endtask

    task automatic test_len_error();
        cfg_expected_len = 16'd4;
        beat(32'hBAD0_0000, 1'b0);
        beat(32'hBAD0_0001, 1'b0);
        beat(32'hBAD0_0002, 1'b1);
        idle();
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL lenerr_done got=%0h exp=0", frame_done); end
        checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL lenerr_flag got=%0h exp=1", err_len); end
        checks++; if (cnt_dropped !== 16'd1) begin failures++; $display("FAIL lenerr_dropped got=%0d exp=1", cnt_dropped); end
        checks++; if (cnt_frames !== 32'd1) begin failures++; $display("FAIL lenerr_frames got=%0d exp=1", cnt_frames); end
        rd_addr = 6'd1;
        @(negedge user_clk);
        checks++; if (rd_data !== 32'hA111_1111) begin failures++; $display("FAIL lenerr_rd1 got=%0h exp=a1111111", rd_data); end
        rd_addr = 6'd2;
        @(negedge user_clk);
        checks++; if (rd_data !== 32'hA222_2222) begin failures++; $display("FAIL lenerr_rd2 got=%0h exp=a2222222", rd_data); end
    endtask

    task automatic test_overflow();
        int done_seen = 0;
        cfg_expected_len = 16'd0;
        for (int i = 0; i < 70; i++) begin
            beat(32'hC000_0000 + 32'(i), (i == 69));
            if (frame_done) done_seen++;
        end
        idle();
        if (frame_done) done_seen++;
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL ovf_no_done got=%0d exp=0", done_seen); end
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0h exp=1", err_overflow); end
        checks++; if (cnt_dropped !== 16'd2) begin failures++; $display("FAIL ovf_dropped got=%0d exp=2", cnt_dropped); end
        checks++; if (frame_len !== 16'd4) begin failures++; $display("FAIL ovf_len_kept got=%0d exp=4", frame_len); end
        beat(32'hB0B0_0000, 1'b0);
        beat(32'hB1B1_1111, 1'b1);
        idle();
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL b_done got=%0h exp=1", frame_done); end
        checks++; if (frame_len !== 16'd2) begin failures++; $display("FAIL b_len got=%0d exp=2", frame_len); end
        checks++; if (cnt_frames !== 32'd2) begin failures++; $display("FAIL b_frames got=%0d exp=2", cnt_frames); end
        rd_addr = 6'd0;
        @(negedge user_clk);
        checks++; if (rd_data !== 32'hB0B0_0000) begin failures++; $display("FAIL b_rd0 got=%0h exp=b0b00000", rd_data); end
        rd_addr = 6'd1;
        @(negedge user_clk);
        checks++; if (rd_data !== 32'hB1B1_1111) begin failures++; $display("FAIL b_rd1 got=%0h exp=b1b11111", rd_data); end
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0h exp=1", err_overflow); end
    endtask

    task automatic test_trigger();
        int seen_at = -1;
        cfg_expected_len = 16'd0;
        cfg_tx_delay     = 16'd10;
        repeat (5) @(negedge user_clk);
        beat(32'h0000_0011, 1'b1);
        idle();
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL trig_one_word_done got=%0h exp=1", frame_done); end
        checks++; if (frame_len !== 16'd1) begin failures++; $display("FAIL trig_one_word_len got=%0d exp=1", frame_len); end
        checks++; if (tx_trigger !== 1'b0) begin failures++; $display("FAIL trig_early got=%0h exp=0", tx_trigger); end
        for (int i = 1; i <= 30; i++) begin
            @(negedge user_clk);
            if (tx_trigger && seen_at < 0) seen_at = i;
        end
        checks++; if (seen_at !== 10) begin failures++; $display("FAIL trig_delay10 got=%0d exp=10", seen_at); end
        cfg_tx_delay = 16'd0;
        beat(32'h0000_0022, 1'b1);
        idle();
        checks++; if ({frame_done, tx_trigger} !== 2'b11) begin failures++; $display("FAIL trig_delay0 got=%0b exp=11", {frame_done, tx_trigger}); end
        @(negedge user_clk);
        checks++; if (tx_trigger !== 1'b0) begin failures++; $display("FAIL trig_delay0_pulse got=%0h exp=0", tx_trigger); end
    endtask

    task automatic test_reset_midframe();
        cfg_expected_len = 16'd4;
        beat(32'hD000_0000, 1'b0);
        beat(32'hD000_0001, 1'b0);
        @(negedge user_clk);
        s_axis_tvalid = 1'b0;
        sys_reset     = 1'b1;
        #1;
        checks++; if (cnt_frames !== 32'd0) begin failures++; $display("FAIL midrst_frames got=%0d exp=0", cnt_frames); end
        checks++; if (cnt_dropped !== 16'd0) begin failures++; $display("FAIL midrst_dropped got=%0d exp=0", cnt_dropped); end
        checks++; if ({err_overflow, err_len} !== 2'b00) begin failures++; $display("FAIL midrst_errs got=%0b exp=00", {err_overflow, err_len}); end
        @(negedge user_clk);
        sys_reset = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'hE000_0000 + 32'(i), (i == 3));
        idle();
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL midrst_done got=%0h exp=1", frame_done); end
        checks++; if (frame_len !== 16'd4) begin failures++; $display("FAIL midrst_len got=%0d exp=4", frame_len); end
        checks++; if (cnt_frames !== 32'd1) begin failures++; $display("FAIL midrst_frames2 got=%0d exp=1", cnt_frames); end
        rd_addr = 6'd3;
        @(negedge user_clk);
        checks++; if (rd_data !== 32'hE000_0003) begin failures++; $display("FAIL midrst_rd3 got=%0h exp=e0000003", rd_data); end
    endtask

`ifdef RTDS_RX_FRAME_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [31:0] ts1, ts2;
        cfg_expected_len = 16'd0;
        beat(32'hF000_0000, 1'b1);
        idle();
        ts1 = frame_ts;
        repeat (98) @(negedge user_clk);
        beat(32'hF000_0001, 1'b1);
        idle();
        ts2 = frame_ts;
        checks++; if (ts2 - ts1 !== 32'd100) begin failures++; $display("FAIL ts_diff got=%0d exp=100", ts2 - ts1); end
    endtask
`endif

    initial begin
        s_axis_tvalid    = 1'b0;
        s_axis_tdata     = '0;
        s_axis_tlast     = 1'b0;
        cfg_expected_len = '0;
        cfg_tx_delay     = '0;
        rd_addr          = '0;
        test_reset();
        test_accept();
        test_len_error();
        test_overflow();
        test_trigger();
        test_reset_midframe();
`ifdef RTDS_RX_FRAME_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtds_rx_frame.md
RTDS_RX_FRAME -- requirements
Module: rtds_rx_frame

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 64, meaning the frame buffer depth in 32-bit words per bank (power of two, 2..1024).
REQ-002 SHALL have parameter DELAY_W, default 16, meaning the width of the TX trigger delay counter.
REQ-003 SHALL have port user_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports s_axis_tvalid (input, 1), s_axis_tdata (input, 32) and s_axis_tlast (input, 1): the Aurora RX stream; there is no tready and the block cannot apply backpressure.
REQ-006 SHALL have port cfg_expected_len, input, 16 bits: expected words per frame; 0 means any length is accepted.
REQ-007 SHALL have port cfg_tx_delay, input, DELAY_W bits: number of cycles from frame acceptance to tx_trigger.
REQ-008 SHALL have ports rd_addr (input, clog2(MAX_WORDS)) and rd_data (output, 32): read port into the published bank.
REQ-009 SHALL have port frame_done, output, 1 bit: single-cycle pulse when a frame is published.
REQ-010 SHALL have port frame_len, output, 16 bits: word count of the published frame.
REQ-011 SHALL have port cnt_frames, output, 32 bits: count of accepted frames.
REQ-012 SHALL have port cnt_dropped, output, 16 bits: count of rejected frames.
REQ-013 SHALL have ports err_overflow and err_len, output, 1 bit each: sticky error flags.
REQ-014 SHALL have port tx_trigger, output, 1 bit: single-cycle pulse that starts transmission back to RTDS.

Function
REQ-015 SHALL buffer frames in two banks; the write bank fills while the other bank is published, and the banks swap only when a frame is accepted.
REQ-016 SHALL run a receive FSM with states IDLE, RECV and DROP.
- IDLE: a beat with tvalid writes word 0 and goes to RECV; if tlast is also set, the frame completes as a one-word frame.
- RECV: each tvalid beat writes at word index wr_cnt and increments wr_cnt.
- DROP: discards beats until a tlast beat, then returns to IDLE.
REQ-017 SHALL treat a beat arriving when wr_cnt equals MAX_WORDS without tlast as an overflow: set err_overflow, go to DROP, and do not swap banks.
REQ-018 SHALL evaluate the frame on its tlast beat, with length L = wr_cnt + 1.
- Accept when cfg_expected_len is 0 or equals L.
- Otherwise reject, set err_len and do not swap banks.
REQ-019 SHALL, on acceptance, swap banks, load frame_len with L, increment cnt_frames (wrapping at 2^32), and assert frame_done exactly one cycle after the tlast beat.
REQ-020 SHALL increment cnt_dropped on every rejected or overflowed frame, saturating at 16'hFFFF.
REQ-021 SHALL return rd_data = published_bank[rd_addr] one cycle after rd_addr is presented.
REQ-022 SHALL apply a bank swap that coincides with a read to reads issued in the next cycle onward.
REQ-023 SHALL run a trigger FSM with states T_IDLE and T_WAIT.
- frame_done loads the delay counter with cfg_tx_delay and moves to T_WAIT.
- tx_trigger pulses when the counter reaches 0; with cfg_tx_delay = 0 it pulses in the same cycle as frame_done.
- A new frame_done during T_WAIT restarts the delay, so only one trigger is issued.
REQ-024 SHALL keep err_overflow and err_len set until reset.
REQ-025 SHALL sample cfg_expected_len only at tlast, and cfg_tx_delay only at frame_done.
REQ-026 SHALL ignore tlast whenever tvalid is low.

Reset
REQ-027 SHALL, on sys_reset assertion, immediately and asynchronously clear all FSMs to IDLE/T_IDLE and all counters, flags, frame_len, frame_done and tx_trigger to 0, and select bank 0 as the write bank.
REQ-028 SHALL not clear buffer contents on reset; rd_data is undefined until the first frame_done.
REQ-029 SHALL discard a frame that is partially received when reset asserts; the first beat after deassertion is word 0 of a new frame.

Configuration
REQ-030 SHALL, when RTDS_RX_FRAME_TIMESTAMP_EN is defined, add a 32-bit free-running cycle counter (reset to 0) and an output frame_ts (32 bits) that is loaded with the counter value on the tlast beat of each accepted frame.
REQ-031 SHALL, when RTDS_RX_FRAME_TIMESTAMP_EN is undefined, omit both frame_ts and the counter entirely.

Structure
REQ-032 SHALL place the receive and trigger FSM state encodings, together with the constant for unlimited expected length (0), in the shared package rtds_pkg.
REQ-033 SHALL implement the two-bank storage as one sub-module, rtds_frame_ram: a simple dual-port RAM with a synchronous read and 2*MAX_WORDS words, addressed as {bank, index}.

Verification
REQ-034 SHALL verify that a 4-word frame A0..A3 with tlast on A3 and cfg_expected_len = 4 gives frame_done one cycle later, frame_len = 4, cnt_frames = 1, and rd_addr 0..3 returns A0..A3.
REQ-035 SHALL verify that a 3-word frame with cfg_expected_len = 4 sets err_len and cnt_dropped = 1, with no frame_done, and the published data remains from the previous frame.
REQ-036 SHALL verify that a 70-word frame with MAX_WORDS = 64 sets err_overflow and discards through tlast, and that a following 2-word frame is accepted with frame_len = 2.
REQ-037 SHALL verify that cfg_tx_delay = 10 gives tx_trigger exactly 10 cycles after frame_done, and that cfg_tx_delay = 0 gives tx_trigger coincident with frame_done.
REQ-038 SHALL verify that sys_reset asserted mid-frame (after 2 of 4 words) clears the counters immediately, and that a post-reset 4-word frame is accepted with frame_len = 4.
REQ-039 SHALL verify, with RTDS_RX_FRAME_TIMESTAMP_EN defined and back-to-back frames 100 cycles apart, that the frame_ts difference is 100.
